// File: rtl/data_bus_mmio.sv
// data_bus_mmio: data-side bus for the pipelined CPU's MEM stage.
// Decodes each access to the word-addressed data RAM or to the peripheral page. The page holds
// a UART transmitter fed by a TX FIFO, a status register and a free-running cycle counter.
// Reads are combinational; writes commit on the rising clock edge.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   d_addr_i    byte address (bits [1:0] ignored)
//   d_wdata_i   store data
//   d_we_i      write enable
//   d_re_i      read enable
//   d_rdata_o   combinational read data, 0 when d_re_i is low
//   uart_tx_o   serial TX line, idles high
//   bus_err_o   sticky flag: an access hit an unmapped address
module data_bus_mmio #(
   parameter int unsigned RAM_WORDS     = 256,
   parameter int unsigned TX_FIFO_DEPTH = 8,
   parameter int unsigned CLKS_PER_BIT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic        d_we_i,
   input  logic        d_re_i,
   output logic [31:0] d_rdata_o,
   output logic        uart_tx_o,
   output logic        bus_err_o
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LastTick  = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   FullCount = (PW + 1)'(TX_FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Address decode
   logic          sel_ram, sel_txd, sel_sts, sel_cyc, sel_none;
   logic [AW-1:0] ram_idx;
   logic          unused_addr;

   assign sel_ram     = (d_addr_i[31:AW+2] == '0);
   assign sel_txd     = (d_addr_i[31:2] == 30'h3FFF_C000);
   assign sel_sts     = (d_addr_i[31:2] == 30'h3FFF_C001);
   assign sel_cyc     = (d_addr_i[31:2] == 30'h3FFF_C002);
   assign sel_none    = ~(sel_ram | sel_txd | sel_sts | sel_cyc);
   assign ram_idx     = d_addr_i[AW+1:2];
   assign unused_addr = ^d_addr_i[1:0];

   // State
   logic [31:0]   ram_q [RAM_WORDS];
   logic [7:0]    fifo_q [TX_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic          ovf_q, bus_err_q;
   logic [31:0]   cyc_q;
   state_e        state_q;
   logic [CW-1:0] tick_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   // FIFO control
   logic fifo_empty, fifo_full, tick_last, pop, push_req, push, drop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FullCount);
   assign tick_last  = (tick_q == LastTick);
   // The transmitter takes a byte when idle, or at the last tick of a stop bit so frames abut.
   assign pop        = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & tick_last));
   assign push_req   = d_we_i & sel_txd;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign push       = push_req & (~fifo_full | pop);
   assign drop       = push_req & fifo_full & ~pop;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Read path
   logic [31:0] status, rd_mux;

   assign status = {16'h0, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, state_q != StIdle};

   always_comb begin
      rd_mux = '0;
      if (sel_ram)      rd_mux = ram_q[ram_idx];
      else if (sel_sts) rd_mux = status;
      else if (sel_cyc) rd_mux = cyc_q;
   end

   assign d_rdata_o = d_re_i ? rd_mux : '0;
   assign uart_tx_o = tx_q;
   assign bus_err_o = bus_err_q;

   // Storage arrays: no reset, RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (d_we_i && sel_ram) ram_q[ram_idx] <= d_wdata_i;
      if (push)              fifo_q[wr_ptr_q] <= d_wdata_i[7:0];
   end

   // FIFO pointers, flags and cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         bus_err_q <= 1'b0;
         cyc_q     <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (drop)                   ovf_q <= 1'b1;
         else if (d_we_i && sel_sts) ovf_q <= 1'b0;
         if ((d_we_i | d_re_i) & sel_none) bus_err_q <= 1'b1;
         cyc_q <= (d_we_i && sel_cyc) ? d_wdata_i : cyc_q + 1'b1;
      end
   end

   // UART transmitter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (pop) begin
                  shift_q <= fifo_q[rd_ptr_q];
                  tx_q    <= 1'b0;
                  tick_q  <= '0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (tick_last) begin
                  tick_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= StData;
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            StData: begin
               if (tick_last) begin
                  tick_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            StStop: begin
               if (tick_last) begin
                  tick_q <= '0;
                  if (pop) begin
                     shift_q <= fifo_q[rd_ptr_q];
                     tx_q    <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_mmio.sv
// Bench for data_bus_mmio: constant vector table, hand sequences for the UART, FIFO overflow,
// unmapped access and mid-frame reset, then random traffic against a transaction-level model.
module tb_data_bus_mmio;

   localparam int unsigned RW    = 256;
   localparam int unsigned AW    = $clog2(RW);
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CPB   = 4;
   localparam logic [31:0] A_TXD = 32'hFFFF_0000;
   localparam logic [31:0] A_STS = 32'hFFFF_0004;
   localparam logic [31:0] A_CYC = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_we, d_re, uart_tx, bus_err;

   data_bus_mmio #(
      .RAM_WORDS    (RW),
      .TX_FIFO_DEPTH(DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .d_addr_i (d_addr),
      .d_wdata_i(d_wdata),
      .d_we_i   (d_we),
      .d_re_i   (d_re),
      .d_rdata_o(d_rdata),
      .uart_tx_o(uart_tx),
      .bus_err_o(bus_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] ram_m [RW];
   bit          ram_v [RW];
   logic [7:0]  q_m[$];      // bytes waiting in the FIFO
   logic [7:0]  line_m[$];   // bytes that have started onto the line, not yet decoded
   bit          act_m, ovf_m, berr_m, model_chk;
   int          e_m, fend_m;
   logic [31:0] cyc_m;

   function automatic int region(input logic [31:0] a);
      if (a < 32'(RW * 4)) return 0;
      case ({a[31:2], 2'b00})
         A_TXD:   return 1;
         A_STS:   return 2;
         A_CYC:   return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic re, input logic [31:0] a,
                                              output bit known);
      logic [AW-1:0] idx;
      idx   = a[AW+1:2];
      known = 1'b1;
      if (!re) return 32'h0;
      case (region(a))
         0: begin
            known = ram_v[idx];
            return ram_m[idx];
         end
         2: return {16'h0, 8'(q_m.size()), 4'h0, ovf_m, q_m.size() == 0,
                    q_m.size() == DEPTH, act_m};
         3: return cyc_m;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic we, input logic re, input logic [31:0] a,
                             input logic [31:0] wd);
      int  pre, rg;
      bit  do_pop;
      logic [AW-1:0] idx;
      idx = a[AW+1:2];
      rg  = region(a);
      e_m++;
      if (act_m && e_m == fend_m) act_m = 1'b0;
      pre    = q_m.size();
      do_pop = !act_m && pre > 0;
      if (do_pop) begin
         line_m.push_back(q_m.pop_front());
         act_m  = 1'b1;
         fend_m = e_m + 10 * CPB;
      end
      if (we && rg == 1) begin
         if (pre < DEPTH || do_pop) q_m.push_back(wd[7:0]);
         else ovf_m = 1'b1;
      end
      if (we && rg == 2) ovf_m = 1'b0;
      cyc_m = (we && rg == 3) ? wd : cyc_m + 32'd1;
      if (we && rg == 0) begin
         ram_m[idx] = wd;
         ram_v[idx] = 1'b1;
      end
      if ((we || re) && rg == 4) berr_m = 1'b1;
   endtask

   task automatic model_reset();
      q_m.delete();
      line_m.delete();
      act_m  = 1'b0;
      ovf_m  = 1'b0;
      berr_m = 1'b0;
      cyc_m  = 32'h0;
   endtask

   // One bus cycle: drive after the edge, sample at the falling edge, model the rising edge.
   task automatic cycle(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output logic tx);
      logic [31:0] exp;
      bit          known;
      d_we = we; d_re = re; d_addr = a; d_wdata = wd;
      @(negedge clk);
      rd = d_rdata; err = bus_err; tx = uart_tx;
      if (model_chk) begin
         exp = model_read(re, a, known);
         if (known) check("rand_rdata", rd, exp);
         check("rand_bus_err", 32'(err), 32'(berr_m));
      end
      @(posedge clk);
      model_edge(we, re, a, wd);
      #1;
      d_we = 1'b0; d_re = 1'b0;
   endtask

   // ---------------- line monitor: decodes frames from uart_tx ----------------
   logic [7:0] got_b[$];
   int         got_t[$];

   initial begin
      logic [7:0] b;
      logic       stop;
      bit         ab;
      int         t0;
      forever begin
         @(negedge clk);
         if (!reset && uart_tx === 1'b0) begin
            t0 = cyc_n;
            ab = 1'b0;
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < CPB; k++) begin
                  @(negedge clk);
                  if (reset) ab = 1'b1;
               end
               b[i] = uart_tx;
            end
            for (int k = 0; k < CPB; k++) begin
               @(negedge clk);
               if (reset) ab = 1'b1;
            end
            stop = uart_tx;
            for (int k = 0; k < CPB - 1; k++) begin
               @(negedge clk);
               if (reset) ab = 1'b1;
            end
            if (!ab) begin
               check("line_stop_bit", 32'(stop), 32'h1);
               got_b.push_back(b);
               got_t.push_back(t0);
               if (line_m.size() == 0) check("line_unexpected_frame", 32'(b), 32'h1FF);
               else check("line_byte", 32'(b), 32'(line_m.pop_front()));
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] rd;
      logic        err, tx;
      logic [9:0]  frame;
      bit          done, tx_low;
      int          nb;

      tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0};
      tbl[3]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF};
      tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h1234_5678};
      tbl[5]  = '{1'b0, 1'b1, A_STS,         32'h0,         32'h0000_0004};
      tbl[6]  = '{1'b0, 1'b1, A_TXD,         32'h0,         32'h0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'hAAAA_5555, 32'h0};
      tbl[8]  = '{1'b0, 1'b1, 32'h0000_03FE, 32'h0,         32'hAAAA_5555};
      tbl[9]  = '{1'b1, 1'b0, A_CYC,         32'hFFFF_FFFE, 32'h0};
      tbl[10] = '{1'b0, 1'b1, A_CYC,         32'h0,         32'hFFFF_FFFE};
      tbl[11] = '{1'b0, 1'b1, 32'hFFFF_000A, 32'h0,         32'hFFFF_FFFF};
      tbl[12] = '{1'b0, 1'b1, A_CYC,         32'h0,         32'h0000_0000};
      tbl[13] = '{1'b0, 1'b1, A_CYC,         32'h0,         32'h0000_0001};

      model_chk = 1'b0;
      d_we = 1'b0; d_re = 1'b0; d_addr = '0; d_wdata = '0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_uart_tx", 32'(uart_tx), 32'h1);
      check("reset_bus_err", 32'(bus_err), 32'h0);
      reset = 1'b0;

      // Table: RAM, read gating, read-during-write, status, cycle counter load and wrap.
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, rd, err, tx);
         check($sformatf("tbl[%0d].rdata", i), rd, tbl[i].exp_rd);
         check($sformatf("tbl[%0d].bus_err", i), 32'(err), 32'h0);
      end

      // Single frame 0xA5.
      frame = {1'b1, 8'hA5, 1'b0};
      cycle(1'b1, 1'b0, A_TXD, 32'h0000_00A5, rd, err, tx);
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("a5_pre_start_tx", 32'(tx), 32'h1);
      check("a5_pre_start_status", rd, 32'h0000_0100);
      for (int k = 0; k < 10 * CPB; k++) begin
         cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
         check($sformatf("a5_tx[%0d]", k), 32'(tx), 32'(frame[k / CPB]));
         check($sformatf("a5_status[%0d]", k), rd, 32'h0000_0005);
      end
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("a5_end_status", rd, 32'h0000_0004);
      check("a5_end_tx", 32'(tx), 32'h1);

      // FIFO overflow with back-to-back frames.
      got_b.delete();
      got_t.delete();
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, A_TXD, 32'(i), rd, err, tx);
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("ovf_status_full", rd, 32'h0000_080B);
      cycle(1'b1, 1'b0, A_STS, 32'hFFFF_FFFF, rd, err, tx);
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("ovf_status_cleared", rd, 32'h0000_0803);
      done = 1'b0;
      for (int k = 0; k < 12 * 10 * CPB && !done; k++) begin
         cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
         if (rd == 32'h0000_0004) done = 1'b1;
      end
      check("ovf_drain_done", 32'(done), 32'h1);
      check("ovf_frame_count", 32'(got_b.size()), 32'd9);
      for (int i = 0; i < got_b.size() && i < 9; i++)
         check($sformatf("ovf_byte[%0d]", i), 32'(got_b[i]), 32'(i));
      for (int i = 1; i < got_t.size(); i++)
         check($sformatf("ovf_frame_spacing[%0d]", i), 32'(got_t[i] - got_t[i-1]),
               32'(10 * CPB));

      // Unmapped access makes bus_err sticky.
      cycle(1'b0, 1'b1, 32'h8000_0000, 32'h0, rd, err, tx);
      check("unmapped_rdata", rd, 32'h0);
      check("unmapped_err_same_cycle", 32'(err), 32'h0);
      cycle(1'b0, 1'b1, 32'h0000_0010, 32'h0, rd, err, tx);
      check("unmapped_err_next", 32'(err), 32'h1);
      check("ram_after_unmapped", rd, 32'h1234_5678);
      cycle(1'b1, 1'b0, 32'h0000_0020, 32'h7, rd, err, tx);
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("unmapped_err_sticky", 32'(err), 32'h1);

      // Reset in the middle of a data bit with bytes still queued.
      cycle(1'b1, 1'b0, A_TXD, 32'h3C, rd, err, tx);
      cycle(1'b1, 1'b0, A_TXD, 32'h5A, rd, err, tx);
      cycle(1'b1, 1'b0, A_TXD, 32'h96, rd, err, tx);
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0, rd, err, tx);
      check("rst_pre_tx_low", 32'(uart_tx), 32'h0);
      #2 reset = 1'b1;
      #1 check("rst_tx_immediate", 32'(uart_tx), 32'h1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
      check("rst_status", rd, 32'h0000_0004);
      check("rst_bus_err", 32'(err), 32'h0);
      check("rst_ram_kept", 32'(ram_m[4]), 32'h1234_5678);
      nb = got_b.size();
      tx_low = 1'b0;
      for (int k = 0; k < 20 * CPB; k++) begin
         cycle(1'b0, 1'b0, 32'h0, 32'h0, rd, err, tx);
         if (tx !== 1'b1) tx_low = 1'b1;
      end
      check("rst_line_quiet", 32'(tx_low), 32'h0);
      check("rst_no_frames", 32'(got_b.size()), 32'(nb));

      // Random traffic against the model.
      model_chk = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         int          r;
         logic        we, re;
         logic [31:0] a, wd;
         r  = int'($urandom_range(0, 99));
         we = 1'($urandom);
         re = 1'($urandom);
         wd = $urandom;
         if (r < 40)      a = {22'h0, 4'($urandom_range(0, 15)), 2'($urandom), 4'h0} >> 2;
         else if (r < 58) a = A_STS | 32'($urandom_range(0, 3));
         else if (r < 66) a = A_CYC | 32'($urandom_range(0, 3));
         else if (r < 78) a = A_TXD | 32'($urandom_range(0, 3));
         else if (r < 80) begin
            case ($urandom_range(0, 2))
               0:       a = 32'h400 + 32'($urandom_range(0, 255));
               1:       a = 32'hFFFF_000C;
               default: a = 32'h8000_0000 | $urandom;
            endcase
         end else begin
            a  = 32'($urandom_range(0, 63));
            re = 1'b0;
         end
         cycle(we, re, a, wd, rd, err, tx);
      end
      done = 1'b0;
      for (int k = 0; k < 10 * CPB * (DEPTH + 2) + 100 && !done; k++) begin
         cycle(1'b0, 1'b1, A_STS, 32'h0, rd, err, tx);
         if (q_m.size() == 0 && !act_m && line_m.size() == 0) done = 1'b1;
      end
      check("rand_drain_done", 32'(done), 32'h1);
      model_chk = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
